ex_muldiv: RTL and testbench

Multi-cycle arithmetic unit of the execute stage. It consumes the operation and operands registered by the ID/EX pipeline register and computes DIV/DIVU with an iterative restoring divider, plus the two-cycle MADD/MADDU/MSUB/MSUBU accumulate. It holds the pipeline through the ctrl stall request until the HI/LO result is ready, then presents it alongside the rest of the EX-stage outputs.

---
 rtl/ex_muldiv_pkg.sv | 38 +++
 rtl/ex_muldiv_div.sv | 67 ++++++
 rtl/ex_muldiv.sv | 166 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared op codes, widths and FSM encoding for the EX-stage multi-cycle unit.
// The MADD_2 state exists only when EX_MADD_EN is defined.
package ex_muldiv_pkg;

  localparam int ALUOP_W = 8;
  localparam int REG_W   = 32;

  localparam logic [ALUOP_W-1:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = 8'b00011011;
  localparam logic [ALUOP_W-1:0] EXE_MADD_OP  = 8'b10100110;
  localparam logic [ALUOP_W-1:0] EXE_MADDU_OP = 8'b10101000;
  localparam logic [ALUOP_W-1:0] EXE_MSUB_OP  = 8'b10101010;
  localparam logic [ALUOP_W-1:0] EXE_MSUBU_OP = 8'b10101011;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DIV_ZERO = 3'd1,
    DIV_ON   = 3'd2,
    DIV_END  = 3'd3
`ifdef EX_MADD_EN
    , MADD_2 = 3'd4
`endif
  } state_e;

  function automatic logic is_div_op(input logic [ALUOP_W-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

  function automatic logic is_madd_op(input logic [ALUOP_W-1:0] op);
    return (op == EXE_MADD_OP) || (op == EXE_MADDU_OP) ||
           (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
  endfunction

  function automatic logic [REG_W-1:0] neg_if(input logic n, input logic [REG_W-1:0] v);
    return n ? (~v + {{(REG_W-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_div.sv
// Restoring divider core: one quotient bit per step, unsigned magnitudes only.
module ex_div_core #(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             last_o,
  output logic [WIDTH-1:0] quot_next_o,
  output logic [WIDTH-1:0] rem_next_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d, dsor_q, dsor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   shifted, diff;

  // quot_q shifts dividend bits out of its top while quotient bits enter at the bottom
  always_comb begin
    shifted = {rem_q, quot_q[WIDTH-1]};
    diff    = shifted - {1'b0, dsor_q};
    if (diff[WIDTH]) begin
      rem_next_o  = shifted[WIDTH-1:0];
      quot_next_o = {quot_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_next_o  = diff[WIDTH-1:0];
      quot_next_o = {quot_q[WIDTH-2:0], 1'b1};
    end

    quot_d = quot_q;
    rem_d  = rem_q;
    dsor_d = dsor_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      quot_d = dividend_i;
      rem_d  = '0;
      dsor_d = divisor_i;
      cnt_d  = '0;
    end else if (step_i) begin
      quot_d = quot_next_o;
      rem_d  = rem_next_o;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  assign last_o = (cnt_q == CNT_W'(DIV_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      dsor_q <= '0;
      cnt_q  <= '0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dsor_q <= dsor_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle unit: signed/unsigned divide and, with EX_MADD_EN defined,
// the two-cycle MADD/MADDU/MSUB/MSUBU accumulate into HI/LO.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [REG_W-1:0]   reg1_i,
  input  logic [REG_W-1:0]   reg2_i,
  input  logic [REG_W-1:0]   hi_i,
  input  logic [REG_W-1:0]   lo_i,
  input  logic               stall_ex_i,
  input  logic               flush_i,
  output logic [REG_W-1:0]   hi_o,
  output logic [REG_W-1:0]   lo_o,
  output logic               whilo_o,
  output logic               stallreq_o,
  output logic               busy_o
);

  state_e           state_q, state_d;
  logic             a_neg_q, a_neg_d, q_neg_q, q_neg_d;
  logic [REG_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             op_signed, a_sign, b_sign;
  logic             div_start, div_last, stall_req, wr_hilo;
  logic [REG_W-1:0] quot_next, rem_next;

  assign op_signed = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_MADD_OP) ||
                     (aluop_i == EXE_MSUB_OP);
  assign a_sign    = op_signed & reg1_i[REG_W-1];
  assign b_sign    = op_signed & reg2_i[REG_W-1];

`ifdef EX_MADD_EN
  logic [2*REG_W-1:0] prod_q, prod_d, madd_res;
  logic               sub_q, sub_d;
  // HI/LO are read in MADD_2 so an older in-flight HI/LO write is already forwarded
  assign madd_res = sub_q ? ({hi_i, lo_i} - prod_q) : ({hi_i, lo_i} + prod_q);
`else
  logic unused_madd;
  assign unused_madd = ^{hi_i, lo_i};
`endif

  ex_div_core #(.WIDTH(REG_W), .DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .step_i      (state_q == DIV_ON),
    .dividend_i  (neg_if(a_sign, reg1_i)),
    .divisor_i   (neg_if(b_sign, reg2_i)),
    .last_o      (div_last),
    .quot_next_o (quot_next),
    .rem_next_o  (rem_next)
  );

  always_comb begin
    state_d   = state_q;
    a_neg_d   = a_neg_q;
    q_neg_d   = q_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_start = 1'b0;
    stall_req = 1'b0;
    wr_hilo   = 1'b0;
`ifdef EX_MADD_EN
    prod_d    = prod_q;
    sub_d     = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (is_div_op(aluop_i)) begin
          stall_req = 1'b1;
          if (reg2_i == '0) begin
            state_d = DIV_ZERO;
          end else begin
            div_start = 1'b1;
            a_neg_d   = a_sign;
            q_neg_d   = a_sign ^ b_sign;
            state_d   = DIV_ON;
          end
        end
`ifdef EX_MADD_EN
        else if (is_madd_op(aluop_i)) begin
          stall_req = 1'b1;
          prod_d    = {{REG_W{a_sign}}, reg1_i} * {{REG_W{b_sign}}, reg2_i};
          sub_d     = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
          state_d   = MADD_2;
        end
`endif
      end
      DIV_ZERO: begin
        stall_req = 1'b1;
        hi_d      = '0;
        lo_d      = '0;
        state_d   = DIV_END;
      end
      DIV_ON: begin
        stall_req = 1'b1;
        if (div_last) begin
          hi_d    = neg_if(a_neg_q, rem_next);
          lo_d    = neg_if(q_neg_q, quot_next);
          state_d = DIV_END;
        end
      end
      DIV_END: begin
        wr_hilo = 1'b1;
        if (!stall_ex_i) state_d = IDLE;
      end
`ifdef EX_MADD_EN
      MADD_2: begin
        wr_hilo = 1'b1;
        hi_d    = madd_res[2*REG_W-1:REG_W];
        lo_d    = madd_res[REG_W-1:0];
        if (!stall_ex_i) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d   = IDLE;
      div_start = 1'b0;
      stall_req = 1'b0;
      wr_hilo   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_neg_q <= 1'b0;
      q_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef EX_MADD_EN
      prod_q  <= '0;
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_neg_q <= a_neg_d;
      q_neg_q <= q_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef EX_MADD_EN
      prod_q  <= prod_d;
      sub_q   <= sub_d;
`endif
    end
  end

`ifdef EX_MADD_EN
  assign hi_o = (state_q == MADD_2) ? madd_res[2*REG_W-1:REG_W] : hi_q;
  assign lo_o = (state_q == MADD_2) ? madd_res[REG_W-1:0]       : lo_q;
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif
  // the IDLE stall request decodes aluop_i directly, so it must be masked while in reset
  assign stallreq_o = stall_req & rst;
  assign whilo_o    = wr_hilo & rst;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed table, randomized ops against a
// plain-arithmetic model, plus flush, reset-abort and back-to-back sequences.
`timescale 1ns/1ps
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0, rst = 1'b0;
  logic [7:0]  aluop = '0;
  logic [31:0] reg1 = '0, reg2 = '0, hi_in = '0, lo_in = '0;
  logic        stall_ex = 1'b0, flush = 1'b0;
  logic [31:0] hi_o, lo_o;
  logic        whilo_o, stallreq_o, busy_o;
  int          vecs = 0, miss = 0;

`ifdef EX_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  ex_muldiv #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .reg1_i(reg1), .reg2_i(reg2),
    .hi_i(hi_in), .lo_i(lo_in), .stall_ex_i(stall_ex), .flush_i(flush),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o), .stallreq_o(stallreq_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a, b, hi, lo;
    int          hold;
    bit          chain;
    int          lat;
    logic [31:0] eh, el;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: {hi,lo} result from plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, b, hi, lo);
    longint      sa, sb, q, m;
    logic [63:0] ua, ub, acc, r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    acc = {hi, lo};
    r   = '0;
    case (op)
      EXE_DIV_OP:   if (b != 0) begin q = sa / sb; m = sa % sb; r = {m[31:0], q[31:0]}; end
      EXE_DIVU_OP:  if (b != 0) begin q = longint'(ua / ub); m = longint'(ua % ub); r = {m[31:0], q[31:0]}; end
      EXE_MADD_OP:  r = acc + 64'(sa * sb);
      EXE_MSUB_OP:  r = acc - 64'(sa * sb);
      EXE_MADDU_OP: r = acc + ua * ub;
      EXE_MSUBU_OP: r = acc - ua * ub;
      default:      r = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [7:0] op, input logic [31:0] b);
    if (op == EXE_DIV_OP || op == EXE_DIVU_OP) return (b == 0) ? 2 : 33;
    return MADD_ON ? 1 : -1;
  endfunction

  // Drive one op at cycle 0; hi/lo are wrong in cycle 0 and correct from cycle 1 on.
  task automatic do_op(input string tag, input logic [7:0] op, input logic [31:0] a, b, hi, lo,
                       input int hold, input int exp_lat, input logic [63:0] exp_res);
    int          lat, stalls;
    logic [31:0] rh, rl;
    lat = -1; stalls = 0; rh = '0; rl = '0;
    @(posedge clk); #1;
    aluop = op; reg1 = a; reg2 = b; hi_in = ~hi; lo_in = ~lo; stall_ex = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) chk({tag, " busy@0"}, 64'(busy_o), 64'(0));
      if (whilo_o) begin
        lat = c; rh = hi_o; rl = lo_o;
        break;
      end
      if (stallreq_o) stalls++;
      @(posedge clk); #1;
      hi_in = hi; lo_in = lo;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " stalls"}, 64'(stalls), 64'((exp_lat < 0) ? 0 : exp_lat));
    if (exp_lat >= 0) chk({tag, " hilo"}, {rh, rl}, exp_res);
    if (lat >= 0 && hold > 0) begin
      stall_ex = 1'b1;
      for (int h = 1; h <= hold; h++) begin
        @(negedge clk);
        chk({tag, " held whilo"}, 64'(whilo_o), 64'(1));
        chk({tag, " held hilo"}, {hi_o, lo_o}, {rh, rl});
        chk({tag, " held stallreq"}, 64'(stallreq_o), 64'(0));
        if (h == hold) stall_ex = 1'b0;
      end
    end
    $display("op %h a=%h b=%h hold=%0d -> lat %0d hi=%h lo=%h", op, a, b, hold, lat, rh, rl);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      aluop = 8'h00; stall_ex = 1'b0;
      @(negedge clk);
      chk("idle whilo", 64'(whilo_o), 64'(0));
      chk("idle stallreq", 64'(stallreq_o), 64'(0));
      chk("idle busy", 64'(busy_o), 64'(0));
    end
  endtask

  vec_t tbl[9];

  initial begin
    int pulses;
    logic [7:0] ops [6];
    ops = '{EXE_DIV_OP, EXE_DIVU_OP, EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP};

    tbl[0] = '{EXE_DIV_OP,   32'd100,        32'd7,          0, 0, 3, 1'b0, 33, 32'd2,        32'd14};
    tbl[1] = '{EXE_DIV_OP,   32'hFFFFFFF9,   32'd2,          0, 0, 0, 1'b1, 33, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[2] = '{EXE_DIVU_OP,  32'hFFFFFFFF,   32'd2,          0, 0, 0, 1'b0, 33, 32'd1,        32'h7FFFFFFF};
    tbl[3] = '{EXE_DIV_OP,   32'd5,          32'd0,          0, 0, 0, 1'b0, 2,  32'd0,        32'd0};
    tbl[4] = '{EXE_DIV_OP,   32'h80000000,   32'hFFFFFFFF,   0, 0, 0, 1'b0, 33, 32'd0,        32'h80000000};
    tbl[5] = '{EXE_DIVU_OP,  32'd7,          32'd16,         0, 0, 0, 1'b0, 33, 32'd7,        32'd0};
    tbl[6] = '{EXE_MADD_OP,  32'd3,          32'hFFFFFFFE,   32'd1, 32'd0, 2, 1'b0, MADD_ON ? 1 : -1, 32'd0, 32'hFFFFFFFA};
    tbl[7] = '{EXE_MSUBU_OP, 32'd2,          32'd3,          32'd0, 32'd10, 0, 1'b0, MADD_ON ? 1 : -1, 32'd0, 32'd4};
    tbl[8] = '{EXE_MADDU_OP, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, MADD_ON ? 1 : -1, 32'd1, 32'hFFFFFFFD};

    // Reset with a divide on the bus: everything must read zero
    aluop = EXE_DIV_OP; reg1 = 32'd100; reg2 = 32'd7;
    #2;
    chk("reset hilo", {hi_o, lo_o}, 64'(0));
    chk("reset whilo", 64'(whilo_o), 64'(0));
    chk("reset stallreq", 64'(stallreq_o), 64'(0));
    chk("reset busy", 64'(busy_o), 64'(0));
    aluop = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nop(1);

    foreach (tbl[i]) begin
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo,
            tbl[i].hold, tbl[i].lat, {tbl[i].eh, tbl[i].el});
      if (!tbl[i].chain) nop(1);
    end

    for (int i = 0; i < 30; i++) begin
      logic [7:0]  op;
      logic [31:0] a, b, hi, lo;
      op = ops[$urandom_range(0, 5)];
      a  = $urandom; b = $urandom; hi = $urandom; lo = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = b >> $urandom_range(8, 31);
        default: ;
      endcase
      do_op($sformatf("rnd%0d", i), op, a, b, hi, lo, $urandom_range(0, 2),
            exp_latency(op, b), model(op, a, b, hi, lo));
      if ($urandom_range(0, 1) == 0) nop(1);
    end
    nop(1);

    // Flush at cycle 10 of a divide
    @(posedge clk); #1;
    aluop = EXE_DIV_OP; reg1 = 32'd1000; reg2 = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("flush stallreq", 64'(stallreq_o), 64'(0));
    chk("flush whilo", 64'(whilo_o), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0; aluop = 8'h00;
    @(negedge clk);
    chk("flush busy", 64'(busy_o), 64'(0));
    pulses = 0;
    repeat (40) begin @(negedge clk); if (whilo_o) pulses++; end
    chk("flush no write", 64'(pulses), 64'(0));

    // Known nonzero HI/LO, then reset at cycle 5 of the next divide
    do_op("pre-reset", EXE_DIV_OP, 32'd100, 32'd7, 0, 0, 0, 33, {32'd2, 32'd14});
    nop(1);
    @(posedge clk); #1;
    aluop = EXE_DIV_OP; reg1 = 32'd77; reg2 = 32'd5;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("midrst hilo", {hi_o, lo_o}, 64'(0));
    chk("midrst whilo", 64'(whilo_o), 64'(0));
    chk("midrst stallreq", 64'(stallreq_o), 64'(0));
    chk("midrst busy", 64'(busy_o), 64'(0));
    aluop = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (40) begin @(negedge clk); if (whilo_o || busy_o) pulses++; end
    chk("midrst no write", 64'(pulses), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
